// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Bundle of the fetch handshake, data-load handshake and
//                data_path control signals of control_sequencer.
//                master = sequencer side, slave = memory / data_path side.
//  Ports (master view):
//    out instruction_request, program_counter       instruction fetch
//    in  instruction_valid, instruction_data         fetch response
//    out memory_request, memory_address              data load request
//    in  memory_valid                                load response
//    out input/output register selectors, output_source_selector,
//        output_enable, alu_opcode, ir_immediate_1/2 data_path controls
//    out halted                                      HALT executed
//  Revision    : 1.0  initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int PC_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH = 16
);
    logic                      instruction_request;
    logic [PC_WIDTH-1:0]       program_counter;
    logic                      instruction_valid;
    logic [31:0]               instruction_data;
    logic                      memory_request;
    logic [MEM_ADDR_WIDTH-1:0] memory_address;
    logic                      memory_valid;
    logic [1:0]                input_register_selector_1;
    logic [1:0]                input_register_selector_2;
    logic [1:0]                output_register_selector;
    logic [1:0]                output_source_selector;
    logic                      output_enable;
    logic [1:0]                alu_opcode;
    logic [31:0]               ir_immediate_1;
    logic [31:0]               ir_immediate_2;
    logic                      halted;

    modport master (
        output instruction_request, program_counter,
        input  instruction_valid, instruction_data,
        output memory_request, memory_address,
        input  memory_valid,
        output input_register_selector_1, input_register_selector_2,
        output output_register_selector, output_source_selector,
        output output_enable, alu_opcode, ir_immediate_1, ir_immediate_2,
        output halted
    );

    modport slave (
        input  instruction_request, program_counter,
        output instruction_valid, instruction_data,
        input  memory_request, memory_address,
        output memory_valid,
        input  input_register_selector_1, input_register_selector_2,
        input  output_register_selector, output_source_selector,
        input  output_enable, alu_opcode, ir_immediate_1, ir_immediate_2,
        input  halted
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Multi-cycle instruction sequencer driving data_path controls.
//                Fetches one 32-bit instruction at a time, decodes it and
//                sequences register-file writeback from ALU, immediate or
//                data memory. One instruction in flight.
//  Ports:
//    clock    in  rising-edge clock
//    reset_n  in  asynchronous active-low reset
//    bus      control_sequencer_if.master (fetch/load handshakes, controls)
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter int PC_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  wire                   clock,
    input  wire                   reset_n,
    control_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXECUTE  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    localparam logic [1:0] CLASS_ALU   = 2'b00;
    localparam logic [1:0] CLASS_LDIMM = 2'b01;
    localparam logic [1:0] CLASS_LDMEM = 2'b10;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [1:0]          w_class;

    assign w_class = ir_q[31:30];

    // State, program counter and instruction register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_d                 = state_q;
        pc_d                    = pc_q;
        ir_d                    = ir_q;
        bus.instruction_request = 1'b0;
        bus.memory_request      = 1'b0;
        bus.output_enable       = 1'b0;
        bus.halted              = 1'b0;

        case (state_q)
            S_FETCH: begin
                // The state register already sits in FETCH while reset is
                // asserted; qualifying with reset_n keeps the request low
                // until reset is released.
                bus.instruction_request = reset_n;
                if (bus.instruction_valid) begin
                    ir_d    = bus.instruction_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (w_class)
                    CLASS_ALU, CLASS_LDIMM: begin
                        bus.output_enable = 1'b1;
                        state_d           = S_FETCH;
                    end
                    CLASS_LDMEM: state_d = S_MEM_WAIT;
                    default:     state_d = S_HALTED;
                endcase
            end
            S_MEM_WAIT: begin
                bus.memory_request = 1'b1;
                if (bus.memory_valid) begin
                    bus.output_enable = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            default: begin
                bus.halted = 1'b1;
            end
        endcase
    end

    // Writeback source follows the instruction class; a load-immediate picks
    // zero- or sign-extension from IR[28].
    always_comb begin
        bus.output_source_selector = 2'd0;
        case (w_class)
            CLASS_LDIMM: bus.output_source_selector = ir_q[28] ? 2'd2 : 2'd1;
            CLASS_LDMEM: bus.output_source_selector = 2'd3;
            default:     bus.output_source_selector = 2'd0;
        endcase
    end

    assign bus.program_counter           = pc_q;
    assign bus.memory_address            = (state_q == S_MEM_WAIT) ?
                                           ir_q[MEM_ADDR_WIDTH-1:0] : '0;
    assign bus.input_register_selector_1 = ir_q[25:24];
    assign bus.input_register_selector_2 = ir_q[23:22];
    assign bus.output_register_selector  = ir_q[27:26];
    assign bus.alu_opcode                = ir_q[29:28];
    assign bus.ir_immediate_1            = {10'b0, ir_q[21:0]};
    assign bus.ir_immediate_2            = {{10{ir_q[21]}}, ir_q[21:0]};

endmodule
`default_nettype wire
